// File: rtl/sdc_busy_wait.sv
// Busy-completion tracker for the SD card DAT0 busy phase: waits for busy to
// assert, enables the falling-edge detector and times the busy period.
module sdc_busy_wait #(
  parameter int CNT_W     = 24,
  parameter int START_WIN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] timeout_val,
  input  logic             busy_lvl,
  input  logic             busy_end_strb,
  output logic             strb_enable,
  output logic             active,
  output logic             done,
  output logic             timed_out,
  output logic             no_busy,
  output logic [CNT_W-1:0] busy_cycles
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_END   = 2'd2,
    FINISH     = 2'd3
  } state_e;

  localparam logic [7:0]       WIN_LAST = 8'(START_WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;
  logic             timed_out_q, timed_out_d;
  logic             no_busy_q, no_busy_d;
  logic             active_q, strb_q, done_q;

  // Next-state and result-latch logic; abort overrides every state, including a start in IDLE.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    busy_cycles_d = busy_cycles_q;
    timed_out_d   = timed_out_q;
    no_busy_d     = no_busy_q;
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d       = WAIT_START;
            win_d         = 8'd0;
            tmo_d         = timeout_val;
            busy_cycles_d = CNT_ZERO;
            timed_out_d   = 1'b0;
            no_busy_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_START: begin
          if (busy_lvl) begin
            state_d = WAIT_END;
            cnt_d   = CNT_ZERO;
          end else if (win_q == WIN_LAST) begin
            state_d       = FINISH;
            no_busy_d     = 1'b1;
            busy_cycles_d = CNT_ZERO;
          end else begin
            win_d = win_q + 8'd1;
          end
        end
        WAIT_END: begin
          // A dropped busy level without a strobe keeps waiting: the detector may lag.
          cnt_d = cnt_inc;
          if (busy_end_strb) begin
            state_d       = FINISH;
            busy_cycles_d = cnt_inc;
            timed_out_d   = 1'b0;
          end else if ((tmo_q != CNT_ZERO) && (cnt_inc == tmo_q)) begin
            state_d       = FINISH;
            busy_cycles_d = tmo_q;
            timed_out_d   = 1'b1;
          end else begin
            state_d = WAIT_END;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= 8'd0;
      cnt_q         <= CNT_ZERO;
      tmo_q         <= CNT_ZERO;
      busy_cycles_q <= CNT_ZERO;
      timed_out_q   <= 1'b0;
      no_busy_q     <= 1'b0;
      active_q      <= 1'b0;
      strb_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      busy_cycles_q <= busy_cycles_d;
      timed_out_q   <= timed_out_d;
      no_busy_q     <= no_busy_d;
      active_q      <= (state_d == WAIT_START) || (state_d == WAIT_END);
      strb_q        <= (state_d == WAIT_END);
      done_q        <= (state_q == FINISH) && !abort;
    end
  end

  assign strb_enable = strb_q;
  assign active      = active_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign no_busy     = no_busy_q;
  assign busy_cycles = busy_cycles_q;

endmodule

// File: tb/tb_sdc_busy_wait.sv
// Randomized self-checking bench for sdc_busy_wait; outcomes are predicted per
// operation from busy delay, strobe position and timeout with plain arithmetic.
module tb_sdc_busy_wait;
  localparam int CNT_W     = 24;
  localparam int START_WIN = 16;
  localparam int BIG       = 1 << 30;

  logic             clk = 1'b0;
  logic             reset, start, abort, busy_lvl, busy_end_strb;
  logic [CNT_W-1:0] timeout_val;
  logic             strb_enable, active, done, timed_out, no_busy;
  logic [CNT_W-1:0] busy_cycles;

  int checks = 0;
  int errors = 0;

  sdc_busy_wait #(.CNT_W(CNT_W), .START_WIN(START_WIN)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .timeout_val(timeout_val), .busy_lvl(busy_lvl), .busy_end_strb(busy_end_strb),
    .strb_enable(strb_enable), .active(active), .done(done),
    .timed_out(timed_out), .no_busy(no_busy), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // d: WAIT_START cycle (0-based) in which busy is first seen, -1 = never.
  // s: WAIT_END cycle (1-based) carrying the strobe, 0 = none. t: timeout, 0 = none.
  task automatic run_op(input int d, input int s, input int t, input string tag);
    int k, tlim, exp_done, exp_to, exp_nb, exp_act, exp_strb;
    int done_at, act_cnt, strb_cnt;
    if (d < 0) begin
      k = 0; exp_to = 0; exp_nb = 1;
      exp_done = START_WIN + 2; exp_act = START_WIN; exp_strb = 0;
    end else begin
      tlim = (t > 0) ? t : BIG;
      if (s > 0 && s <= tlim) begin k = s; exp_to = 0; end
      else begin k = t; exp_to = 1; end
      exp_nb = 0; exp_done = d + 3 + k; exp_act = d + 1 + k; exp_strb = k;
    end
    done_at = -1; act_cnt = 0; strb_cnt = 0;
    for (int c = 0; c <= exp_done + 3 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, ":prev_done_low"}, done, 0);
      if (c == 1) begin
        check({tag, ":start_clr"}, {timed_out, no_busy, busy_cycles}, 0);
        check({tag, ":active_on"}, active, 1);
      end
      if (c >= 1) begin
        act_cnt  += int'(active);
        strb_cnt += int'(strb_enable);
      end
      if (done === 1'b1) begin
        done_at = c;
        check({tag, ":timed_out"}, timed_out, exp_to);
        check({tag, ":no_busy"}, no_busy, exp_nb);
        check({tag, ":busy_cycles"}, busy_cycles, k);
        start = 1'b0; busy_lvl = 1'b0; busy_end_strb = 1'b0;
      end else begin
        start = (c == 0) ? 1'b1 : (c <= exp_done - 1 && $urandom_range(0, 9) == 0);
        timeout_val = (c == 0) ? CNT_W'(t) : CNT_W'($urandom);
        if (d >= 0 && c == d + 1) busy_lvl = 1'b1;
        else if (d >= 0 && c > d + 1) busy_lvl = ($urandom_range(0, 3) != 0);
        else busy_lvl = 1'b0;
        if (d >= 0 && s > 0 && c == d + 1 + s) busy_end_strb = 1'b1;
        else if (d < 0 || c <= d + 1) busy_end_strb = ($urandom_range(0, 4) == 0);
        else busy_end_strb = 1'b0;
      end
    end
    if (done_at < 0) check({tag, ":done_seen"}, 0, 1);
    else begin
      check({tag, ":latency"}, done_at, exp_done);
      check({tag, ":active_cycles"}, act_cnt, exp_act);
      check({tag, ":strb_cycles"}, strb_cnt, exp_strb);
    end
  endtask

  // Abort (or reset when use_rst) in WAIT_END cycle a; no done may follow.
  task automatic run_kill(input int d, input int a, input bit use_rst, input string tag);
    int ca, done_cnt;
    ca = d + 1 + a; done_cnt = 0;
    for (int c = 0; c <= ca + 8; c++) begin
      @(negedge clk);
      done_cnt += int'(done);
      if (c == ca) check({tag, ":strb_before"}, strb_enable, 1);
      if (use_rst && c == ca + 1)
        check({tag, ":rst_outs"}, {strb_enable, active, done, timed_out, no_busy, busy_cycles}, 0);
      if (!use_rst && c == ca + 2) check({tag, ":act_strb_off"}, {active, strb_enable}, 0);
      start         = (c == 0) || (c == 3);
      timeout_val   = (c == 0) ? CNT_W'(1000) : CNT_W'($urandom);
      busy_lvl      = (c >= d + 1 && c <= ca);
      busy_end_strb = (c == ca + 3);
      abort         = !use_rst && (c == ca);
      reset         = use_rst && (c == ca);
    end
    abort = 1'b0; reset = 1'b0; start = 1'b0; busy_end_strb = 1'b0;
    check({tag, ":no_done"}, done_cnt, 0);
    check({tag, ":flags"}, {timed_out, no_busy, busy_cycles}, 0);
  endtask

  initial begin
    int d, s, t;
    reset = 1'b1; start = 1'b0; abort = 1'b0; busy_lvl = 1'b0; busy_end_strb = 1'b0;
    timeout_val = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {strb_enable, active, done, timed_out, no_busy, busy_cycles}, 0);
    reset = 1'b0;

    run_op(3, 50, 1000, "normal");
    run_op(-1, 0, 1000, "nobusy");
    run_op(1, 0, 20, "timeout");
    run_op(1, 20, 20, "tie");
    run_op(2, 5000, 0, "no_tmo");
    run_kill(2, 10, 1'b0, "abort");
    run_kill(2, 10, 1'b1, "reset");
    run_op(0, 1, 5, "min");
    run_op(START_WIN - 1, 3, 0, "win_edge");
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, START_WIN - 1));
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
      t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
      if (s == 0 && t == 0) t = 30;
      run_op(d, s, t, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
